// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared state enum, BCD type and BCD step helper
// used by the stopwatch top and its mod-60 digit counters.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    PAUSED  = 2'd2
  } state_t;

  typedef logic [7:0] bcd_t;

  localparam bcd_t BCD_MAX = 8'h59;

  // Next BCD value in 00..59, wrapping 59 -> 00.
  function automatic bcd_t bcd_step(bcd_t v);
    bcd_t r;
    if (v >= BCD_MAX) begin
      r = 8'h00;
    end else if (v[3:0] >= 4'd9) begin
      r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_mod60_counter.sv
// bcd_mod60_counter: two-digit BCD counter 00..59 with clear.
// Ports: clk, reset (async, low), inc, clr -> value (BCD), carry.
module bcd_mod60_counter
  import stopwatch_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       inc,
  input  logic       clr,
  output logic [7:0] value,
  output logic       carry
);

  bcd_t value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (clr) begin
      value_d = 8'h00;
    end else if (inc) begin
      value_d = bcd_step(value_q);
    end
  end

  // Carry is combinational so the next digit pair steps on
  // the same edge as this one wraps.
  assign carry = inc & ~clr & (value_q == BCD_MAX);
  assign value = value_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) value_q <= 8'h00;
    else        value_q <= value_d;
  end

endmodule

// File: rtl/stopwatch_counter.sv
// stopwatch_counter: count-up MM:SS BCD stopwatch with pushbutton
// control and optional lap hold (macro STOPWATCH_LAP_EN).
// Ports: clk, reset (async, low), startStop/lap (raw, low),
//   secs/mins (BCD), running, lapHeld, rollover (1-cycle pulse).
module stopwatch_counter
  import stopwatch_pkg::*;
#(
  parameter int TICKS_PER_SEC = 50000000
)
(
  input  logic       clk,
  input  logic       reset,
  input  logic       startStop,
  input  logic       lap,
  output logic [7:0] secs,
  output logic [7:0] mins,
  output logic       running,
  output logic       lapHeld,
  output logic       rollover
);

  localparam int TW = $clog2(TICKS_PER_SEC);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_SEC - 1);

  // vld_q fills with ones as real pin samples reach sync1, sync2
  // and prev; until then the reset "released" history must not
  // be compared against a button held through reset.
  logic [2:0] vld_q;
  logic       ss_s1_q, ss_s2_q, ss_prev_q;
  logic       lp_s1_q, lp_s2_q, lp_prev_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_q     <= 3'b000;
      ss_s1_q   <= 1'b1;
      ss_s2_q   <= 1'b1;
      ss_prev_q <= 1'b1;
      lp_s1_q   <= 1'b1;
      lp_s2_q   <= 1'b1;
      lp_prev_q <= 1'b1;
    end else begin
      vld_q     <= {vld_q[1:0], 1'b1};
      ss_s1_q   <= startStop;
      ss_s2_q   <= ss_s1_q;
      ss_prev_q <= ss_s2_q;
      lp_s1_q   <= lap;
      lp_s2_q   <= lp_s1_q;
      lp_prev_q <= lp_s2_q;
    end
  end

  logic ss_ev, lp_ev, lp_act;

  assign ss_ev  = vld_q[2] & ss_prev_q & ~ss_s2_q;
  assign lp_ev  = vld_q[2] & lp_prev_q & ~lp_s2_q;
  // startStop wins a same-cycle collision.
  assign lp_act = lp_ev & ~ss_ev;

  state_t        state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic          tick_inc, clr;
  bcd_t          sec_val, min_val, sec_nxt, min_nxt;
  logic          sec_carry, min_carry;
  bcd_t          disp_secs_q, disp_secs_d;
  bcd_t          disp_mins_q, disp_mins_d;
  logic          running_q, running_d;
  logic          rollover_q, rollover_d;
`ifdef STOPWATCH_LAP_EN
  logic          lap_held_q, lap_held_d;
  bcd_t          lap_secs_q, lap_secs_d;
  bcd_t          lap_mins_q, lap_mins_d;
`endif

  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q;
    clr        = 1'b0;
`ifdef STOPWATCH_LAP_EN
    lap_held_d = lap_held_q;
    lap_secs_d = lap_secs_q;
    lap_mins_d = lap_mins_q;
`endif
    tick_inc = (state_q == RUNNING) && (tick_q == TICK_LAST);
    if (state_q == RUNNING) begin
      tick_d = tick_inc ? '0 : tick_q + TW'(1);
    end
    unique case (1'b1)
      ss_ev: begin
        unique case (state_q)
          IDLE:    state_d = RUNNING;
          RUNNING: state_d = PAUSED;
          PAUSED:  state_d = RUNNING;
          default: state_d = IDLE;
        endcase
      end
      (lp_act && state_q == PAUSED): begin
        state_d    = IDLE;
        tick_d     = '0;
        clr        = 1'b1;
`ifdef STOPWATCH_LAP_EN
        lap_held_d = 1'b0;
        lap_secs_d = 8'h00;
        lap_mins_d = 8'h00;
`endif
      end
`ifdef STOPWATCH_LAP_EN
      (lp_act && state_q == RUNNING): begin
        lap_held_d = ~lap_held_q;
        if (!lap_held_q) begin
          lap_secs_d = sec_val;
          lap_mins_d = min_val;
        end
      end
`endif
      default: ;
    endcase
  end

  bcd_mod60_counter u_sec (
    .clk   (clk),
    .reset (reset),
    .inc   (tick_inc),
    .clr   (clr),
    .value (sec_val),
    .carry (sec_carry)
  );

  bcd_mod60_counter u_min (
    .clk   (clk),
    .reset (reset),
    .inc   (sec_carry),
    .clr   (clr),
    .value (min_val),
    .carry (min_carry)
  );

  // Next live value, so the display can be a plain register
  // that lands on the same edge as the counters.
  always_comb begin
    sec_nxt = sec_val;
    min_nxt = min_val;
    if (clr) begin
      sec_nxt = 8'h00;
      min_nxt = 8'h00;
    end else begin
      if (tick_inc)  sec_nxt = bcd_step(sec_val);
      if (sec_carry) min_nxt = bcd_step(min_val);
    end
  end

  always_comb begin
    running_d   = (state_d == RUNNING);
    rollover_d  = min_carry;
`ifdef STOPWATCH_LAP_EN
    disp_secs_d = lap_held_d ? lap_secs_d : sec_nxt;
    disp_mins_d = lap_held_d ? lap_mins_d : min_nxt;
`else
    disp_secs_d = sec_nxt;
    disp_mins_d = min_nxt;
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      tick_q      <= '0;
      running_q   <= 1'b0;
      rollover_q  <= 1'b0;
      disp_secs_q <= 8'h00;
      disp_mins_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      tick_q      <= tick_d;
      running_q   <= running_d;
      rollover_q  <= rollover_d;
      disp_secs_q <= disp_secs_d;
      disp_mins_q <= disp_mins_d;
    end
  end

`ifdef STOPWATCH_LAP_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lap_held_q <= 1'b0;
      lap_secs_q <= 8'h00;
      lap_mins_q <= 8'h00;
    end else begin
      lap_held_q <= lap_held_d;
      lap_secs_q <= lap_secs_d;
      lap_mins_q <= lap_mins_d;
    end
  end
  assign lapHeld = lap_held_q;
`else
  assign lapHeld = 1'b0;
`endif

  assign secs     = disp_secs_q;
  assign mins     = disp_mins_q;
  assign running  = running_q;
  assign rollover = rollover_q;

endmodule
